// File: rtl/fp_pkg.sv
// Shared types and constants for the FP add/sub normalise/round back end.
// norm_t is the register between the normalise and round/pack stages.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int SIG_W   = 27;
    // Two extra bits so exp_in+1 and exp_in-LZC never wrap
    localparam int EXPS_W  = EXP_W + 2;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic [SIG_W-1:0]  sig;
        logic              sticky;
        logic [EXPS_W-1:0] exp;
        logic              sign;
        logic              zero;
    } norm_t;

    function automatic fp32_t fp_inf(input logic sign);
        fp32_t f;
        f.sign = sign;
        f.exp  = '1;
        f.frac = '0;
        return f;
    endfunction

    function automatic fp32_t fp_zero(input logic sign);
        fp32_t f;
        f.sign = sign;
        f.exp  = '0;
        f.frac = '0;
        return f;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_cnt
);

    // Ascending scan: the last hit is the most significant set bit
    always_comb begin
        o_cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_cnt = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Normalise (carry right-shift or LZC left-shift), round-to-nearest-even and
// pack IEEE-754 single; two-stage valid/ready pipeline.
module fp_norm_round #(
    parameter int WIDTH = 27,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_res,
    input  logic             i_carry,
    input  logic             i_eop,
    input  logic             i_sign_sub,
    input  logic             i_sign_in,
    input  logic [EXP_W-1:0] i_exp_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_result,
    output logic             o_ovf,
    output logic             o_unf
);
    import fp_pkg::*;

    localparam int LZ_W = $clog2(WIDTH) + 1;
    localparam logic signed [EXPS_W-1:0] EXP_MAX_S = EXPS_W'(EXP_MAX);
    localparam logic signed [EXPS_W-1:0] EXP_ONE_S = EXPS_W'(1);

    logic                     r_s1_v;
    norm_t                    r_s1;
    logic                     r_s2_v;
    fp32_t                    r_result;
    logic                     r_ovf;
    logic                     r_unf;

    logic                     w_s1_en;
    logic                     w_s2_en;
    logic                     w_carry_norm;
    logic [LZ_W-1:0]          w_lz;
    logic signed [EXPS_W-1:0] w_exp_in_s;
    logic signed [EXPS_W-1:0] w_lz_s;
    norm_t                    w_norm;

    logic                     w_g;
    logic                     w_r;
    logic                     w_s;
    logic                     w_l;
    logic                     w_round_up;
    logic                     w_rnd_co;
    logic [MAN_W:0]           w_frac24;
    logic signed [EXPS_W-1:0] w_exp;
    logic signed [EXPS_W-1:0] w_exp_r;
    fp32_t                    w_res;
    logic                     w_ovf;
    logic                     w_unf;

    assign w_s2_en     = !r_s2_v || i_out_ready;
    assign w_s1_en     = !r_s1_v || w_s2_en;
    assign o_in_ready  = w_s1_en;
    assign o_out_valid = r_s2_v;
    assign o_result    = r_result;
    assign o_ovf       = r_ovf;
    assign o_unf       = r_unf;

    // ---------------- stage 1: normalise ----------------
    assign w_carry_norm = i_carry && !i_eop;
    assign w_exp_in_s   = EXPS_W'(i_exp_in);
    assign w_lz_s       = EXPS_W'(w_lz);

    fp_lzc #(
        .WIDTH (WIDTH),
        .CNT_W (LZ_W)
    ) u_lzc (
        .i_data (i_res),
        .o_cnt  (w_lz)
    );

    always_comb begin
        w_norm      = '0;
        w_norm.sign = i_sign_in ^ (i_eop & i_sign_sub);
        if (w_carry_norm) begin
            w_norm.sig    = {1'b1, i_res[WIDTH-1:1]};
            w_norm.sticky = i_res[0];
            w_norm.exp    = w_exp_in_s + EXP_ONE_S;
        end else begin
            w_norm.sig  = i_res << w_lz;
            w_norm.exp  = w_exp_in_s - w_lz_s;
            w_norm.zero = (i_res == '0);
        end
    end

    // ---------------- stage 2: round and pack ----------------
    assign w_exp      = r_s1.exp;
    assign w_l        = r_s1.sig[3];
    assign w_g        = r_s1.sig[2];
    assign w_r        = r_s1.sig[1];
    assign w_s        = r_s1.sig[0] | r_s1.sticky;
    assign w_round_up = w_g & (w_r | w_s | w_l);

    // On carry-out frac24 wraps to zero, which is exactly the required fraction
    assign {w_rnd_co, w_frac24} = {1'b0, r_s1.sig[WIDTH-1:3]} + {{(MAN_W+1){1'b0}}, w_round_up};
    assign w_exp_r = w_rnd_co ? (w_exp + EXP_ONE_S) : w_exp;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (r_s1.zero) begin
            w_res = '0;
        end else if (w_exp[EXPS_W-1] || (w_exp == '0)) begin
            w_res = fp_zero(r_s1.sign);
            w_unf = 1'b1;
        end else if (w_exp_r >= EXP_MAX_S) begin
            w_res = fp_inf(r_s1.sign);
            w_ovf = 1'b1;
        end else begin
            w_res.sign = r_s1.sign;
            w_res.exp  = w_exp_r[EXP_W-1:0];
            w_res.frac = w_frac24[MAN_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1     <= '0;
            r_s2_v   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_s1_en) begin
                r_s1_v <= i_in_valid;
                if (i_in_valid) begin
                    r_s1 <= w_norm;
                end
            end
            if (w_s2_en) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_result <= w_res;
                    r_ovf    <= w_ovf;
                    r_unf    <= w_unf;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed corner cases plus randomized
// traffic with random backpressure, scored against an arithmetic RNE model.
module tb_fp_norm_round;

    logic        clk;
    logic        rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [26:0] i_res;
    logic        i_carry;
    logic        i_eop;
    logic        i_sign_sub;
    logic        i_sign_in;
    logic [7:0]  i_exp_in;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_result;
    logic        o_ovf;
    logic        o_unf;

    int          n_checks;
    int          n_errors;
    int          n_acc;
    int          n_out;
    int          n_drop;
    logic        acc;
    logic [31:0] last_res;
    logic        last_ovf;
    logic        last_unf;
    logic [33:0] exp_q[$];

    fp_norm_round #(.WIDTH(27), .EXP_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_res       (i_res),
        .i_carry     (i_carry),
        .i_eop       (i_eop),
        .i_sign_sub  (i_sign_sub),
        .i_sign_in   (i_sign_in),
        .i_exp_in    (i_exp_in),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_result    (o_result),
        .o_ovf       (o_ovf),
        .o_unf       (o_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: treat the adder output as an integer, round it exactly to 24 bits (RNE)
    function automatic logic [33:0] model(input logic [26:0] res, input logic carry,
                                          input logic eop, input logic ss,
                                          input logic si, input logic [7:0] ein);
        longint m, mant, rem, half;
        int     p, e, sh;
        logic   s, up;
        m = longint'(res);
        if (carry && !eop) m = m + (longint'(1) << 27);
        s = si ^ (eop & ss);
        if (m == 0) return 34'd0;
        p = 0;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        e  = int'(ein) + p - 26;
        up = 1'b0;
        if (p >= 23) begin
            sh   = p - 23;
            mant = m >> sh;
            rem  = m - (mant << sh);
            if (sh > 0) begin
                half = longint'(1) << (sh - 1);
                up   = (rem > half) || (rem == half && mant[0]);
            end
        end else begin
            mant = m << (23 - p);
        end
        if (e <= 0) return {2'b01, s, 31'd0};
        mant = mant + longint'(up);
        if (mant == (longint'(1) << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        return {2'b00, s, e[7:0], mant[22:0]};
    endfunction

    // Inputs are set at a falling edge; handshakes are evaluated 1 ns later and
    // take effect at the next rising edge.
    task automatic tick();
        logic [33:0] e;
        #1;
        if (o_out_valid && i_out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", o_result, e[31:0]);
                chk("ovf", {31'd0, o_ovf}, {31'd0, e[33]});
                chk("unf", {31'd0, o_unf}, {31'd0, e[32]});
                last_res = o_result;
                last_ovf = o_ovf;
                last_unf = o_unf;
            end
        end
        acc = 1'b0;
        if (i_in_valid && o_in_ready) begin
            exp_q.push_back(model(i_res, i_carry, i_eop, i_sign_sub, i_sign_in, i_exp_in));
            n_acc++;
            acc = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic set_beat(input logic [26:0] res, input logic carry, input logic eop,
                            input logic ss, input logic si, input logic [7:0] ein);
        i_res      = res;
        i_carry    = carry;
        i_eop      = eop;
        i_sign_sub = ss;
        i_sign_in  = si;
        i_exp_in   = ein;
        i_in_valid = 1'b1;
    endtask

    task automatic send(input logic [26:0] res, input logic carry, input logic eop,
                        input logic ss, input logic si, input logic [7:0] ein);
        int n;
        set_beat(res, carry, eop, ss, si, ein);
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        i_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    initial begin
        int          base_acc;
        int          base_out;
        logic [31:0] held;
        logic [26:0] rr;

        n_checks = 0; n_errors = 0; n_acc = 0; n_out = 0; n_drop = 0;
        acc = 1'b0; last_res = '0; last_ovf = 1'b0; last_unf = 1'b0;
        rst_n = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b1;
        i_res = '0; i_carry = 1'b0; i_eop = 1'b0; i_sign_sub = 1'b0;
        i_sign_in = 1'b0; i_exp_in = '0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_flags", {30'd0, o_ovf, o_unf}, 32'd0);
        chk("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // carry normalise: {1,res>>1} = 1.1b, exponent 127+1 -> 3.0
        set_beat(27'h400_0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd127);
        tick();
        i_in_valid = 1'b0;
        chk("lat_stage1", {31'd0, o_out_valid}, 32'd0);
        tick();
        chk("lat_stage2", {31'd0, o_out_valid}, 32'd1);
        chk("carry_norm", o_result, 32'h4040_0000);
        drain();

        send(27'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd130);
        drain();
        chk("exact_cancel", last_res, 32'h0000_0000);
        chk("cancel_flags", {30'd0, last_ovf, last_unf}, 32'd0);

        send(27'h400_0004, 1'b0, 1'b0, 1'b0, 1'b0, 8'd127);
        drain();
        chk("rne_tie_even", last_res, 32'h3F80_0000);
        send(27'h400_000C, 1'b0, 1'b0, 1'b0, 1'b0, 8'd127);
        drain();
        chk("rne_tie_odd", last_res, 32'h3F80_0002);
        send(27'h7FF_FFFC, 1'b0, 1'b0, 1'b0, 1'b1, 8'd127);
        drain();
        chk("rne_mant_carry", last_res, 32'hC000_0000);

        send(27'h400_0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd254);
        drain();
        chk("overflow", last_res, 32'h7F80_0000);
        chk("ovf_flag", {31'd0, last_ovf}, 32'd1);
        send(27'h000_0008, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3);
        drain();
        chk("underflow", last_res, 32'h8000_0000);
        chk("unf_flag", {31'd0, last_unf}, 32'd1);

        // backpressure: two beats fit, third stalls until the output drains
        i_out_ready = 1'b0;
        base_acc = n_acc;
        base_out = n_out;
        set_beat(27'h400_0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd100); tick();
        set_beat(27'h400_0008, 1'b0, 1'b0, 1'b0, 1'b0, 8'd101); tick();
        set_beat(27'h600_0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd102); tick();
        chk("bp_accepted", n_acc - base_acc, 32'd2);
        chk("bp_in_ready", {31'd0, o_in_ready}, 32'd0);
        held = o_result;
        tick();
        chk("bp_hold", o_result, held);
        chk("bp_hold_valid", {31'd0, o_out_valid}, 32'd1);
        i_out_ready = 1'b1;
        for (int n = 0; n < 10 && !acc; n++) tick();
        i_in_valid = 1'b0;
        drain();
        chk("bp_acc_total", n_acc - base_acc, 32'd3);
        chk("bp_out_total", n_out - base_out, 32'd3);

        // reset with both stages full
        i_out_ready = 1'b0;
        set_beat(27'h500_0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd90); tick();
        set_beat(27'h500_0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd91); tick();
        i_in_valid = 1'b0;
        chk("pre_rst_full", {30'd0, o_out_valid, o_in_ready}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'd0, o_out_valid}, 32'd0);
        n_drop = n_drop + exp_q.size();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        i_out_ready = 1'b1;
        base_out = n_out;
        repeat (5) tick();
        chk("rst_no_output", n_out - base_out, 32'd0);

        // randomized traffic with random backpressure
        for (int c = 0; c < 1500; c++) begin
            if (!i_in_valid || acc) begin
                rr = 27'($urandom);
                if ($urandom_range(0, 2) == 0) rr = rr >> $urandom_range(0, 27);
                if ($urandom_range(0, 15) == 0) rr = '0;
                i_res      = rr;
                i_carry    = 1'($urandom);
                i_eop      = 1'($urandom);
                i_sign_sub = 1'($urandom);
                i_sign_in  = 1'($urandom);
                case ($urandom_range(0, 3))
                    0:       i_exp_in = 8'($urandom_range(0, 30));
                    1:       i_exp_in = 8'($urandom_range(240, 255));
                    default: i_exp_in = 8'($urandom);
                endcase
                i_in_valid = ($urandom_range(0, 3) != 0);
            end
            i_out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        chk("rand_conservation", n_out, n_acc - n_drop);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
